// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID->EX operand register with forwarding and load-use stall
// Resolves ALU operands, holds decode on load-use hazards and presents a valid/ready handshake.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int SHAMT_WIDTH    = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  logic [4:0]                id_alu_op_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     id_imm_i,
  input  logic                      id_use_imm_i,
  input  logic                      fwd_ex_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_ex_rd_i,
  input  logic [DATA_WIDTH-1:0]     fwd_ex_data_i,
  input  logic                      fwd_ex_is_load_i,
  input  logic                      fwd_wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     fwd_wb_data_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [DATA_WIDTH-1:0]     operands_a_o,
  output logic [DATA_WIDTH-1:0]     operands_b_o,
  output logic [4:0]                alu_op_o,
  output logic [SHAMT_WIDTH-1:0]    shamt_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [PERF_WIDTH-1:0]     stall_cnt_o
);

  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_op_a;
  logic [DATA_WIDTH-1:0]     r_op_b;
  logic [4:0]                r_alu_op;
  logic [SHAMT_WIDTH-1:0]    r_shamt;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [PERF_WIDTH-1:0]     r_stall_cnt;

  logic [DATA_WIDTH-1:0]     w_rs1_val;
  logic [DATA_WIDTH-1:0]     w_rs2_val;
  logic [DATA_WIDTH-1:0]     w_op_b;
  logic                      w_free;
  logic                      w_hazard;
  logic                      w_ready;
  logic                      w_capture;

  // EX result is younger than WB, so it wins when both target the same register.
  always_comb begin
    w_rs1_val = id_rs1_data_i;
    if (id_rs1_addr_i == '0)
      w_rs1_val = '0;
    else if (fwd_ex_valid_i && (fwd_ex_rd_i == id_rs1_addr_i))
      w_rs1_val = fwd_ex_data_i;
    else if (fwd_wb_valid_i && (fwd_wb_rd_i == id_rs1_addr_i))
      w_rs1_val = fwd_wb_data_i;
  end

  always_comb begin
    w_rs2_val = id_rs2_data_i;
    if (id_rs2_addr_i == '0)
      w_rs2_val = '0;
    else if (fwd_ex_valid_i && (fwd_ex_rd_i == id_rs2_addr_i))
      w_rs2_val = fwd_ex_data_i;
    else if (fwd_wb_valid_i && (fwd_wb_rd_i == id_rs2_addr_i))
      w_rs2_val = fwd_wb_data_i;
  end

  assign w_op_b = id_use_imm_i ? id_imm_i : w_rs2_val;

  assign w_free   = !r_valid || ex_ready_i;
  assign w_hazard = id_valid_i && fwd_ex_valid_i && fwd_ex_is_load_i && (fwd_ex_rd_i != '0) &&
                    ((fwd_ex_rd_i == id_rs1_addr_i) ||
                     (!id_use_imm_i && (fwd_ex_rd_i == id_rs2_addr_i)));
  assign w_ready   = w_free && !w_hazard && !rst_i && !flush_i;
  assign w_capture = id_valid_i && w_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_alu_op    <= '0;
      r_shamt     <= '0;
      r_rd        <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid  <= 1'b1;
        r_op_a   <= w_rs1_val;
        r_op_b   <= w_op_b;
        r_alu_op <= id_alu_op_i;
        r_shamt  <= w_op_b[SHAMT_WIDTH-1:0];
        r_rd     <= id_rd_addr_i;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
      // Only stalls that actually insert a bubble are counted; a flushed instruction never stalls.
      if (w_free && w_hazard && !flush_i && (r_stall_cnt != {PERF_WIDTH{1'b1}}))
        r_stall_cnt <= r_stall_cnt + PERF_WIDTH'(1);
    end
  end

  assign id_ready_o   = w_ready;
  assign ex_valid_o   = r_valid;
  assign operands_a_o = r_op_a;
  assign operands_b_o = r_op_b;
  assign alu_op_o     = r_alu_op;
  assign shamt_o      = r_shamt;
  assign rd_addr_o    = r_rd;
  assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int AW = 5;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, id_valid_i, id_ready_o;
  logic [4:0]    id_alu_op_i;
  logic [AW-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [DW-1:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic          id_use_imm_i;
  logic          fwd_ex_valid_i, fwd_ex_is_load_i, fwd_wb_valid_i;
  logic [AW-1:0] fwd_ex_rd_i, fwd_wb_rd_i;
  logic [DW-1:0] fwd_ex_data_i, fwd_wb_data_i;
  logic          ex_valid_o, ex_ready_i;
  logic [DW-1:0] operands_a_o, operands_b_o;
  logic [4:0]    alu_op_o;
  logic [SW-1:0] shamt_o;
  logic [AW-1:0] rd_addr_o;
  logic [PW-1:0] stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_operand_stage #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW), .REG_ADDR_WIDTH(AW), .PERF_WIDTH(PW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_alu_op_i(id_alu_op_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_use_imm_i(id_use_imm_i),
    .fwd_ex_valid_i(fwd_ex_valid_i), .fwd_ex_rd_i(fwd_ex_rd_i), .fwd_ex_data_i(fwd_ex_data_i),
    .fwd_ex_is_load_i(fwd_ex_is_load_i),
    .fwd_wb_valid_i(fwd_wb_valid_i), .fwd_wb_rd_i(fwd_wb_rd_i), .fwd_wb_data_i(fwd_wb_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .operands_a_o(operands_a_o), .operands_b_o(operands_b_o), .alu_op_o(alu_op_o),
    .shamt_o(shamt_o), .rd_addr_o(rd_addr_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 0; flush_i = 0; id_valid_i = 0; id_alu_op_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0;
    id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0; id_use_imm_i = 0;
    fwd_ex_valid_i = 0; fwd_ex_rd_i = 0; fwd_ex_data_i = 0; fwd_ex_is_load_i = 0;
    fwd_wb_valid_i = 0; fwd_wb_rd_i = 0; fwd_wb_data_i = 0; ex_ready_i = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1; id_valid_i = 1; id_rs1_addr_i = 3; id_rs1_data_i = 9;
    #1;
    n_checks++;
    if (id_ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", id_ready_o); end
    step(); step();
    n_checks++;
    if (ex_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", ex_valid_o); end
    n_checks++;
    if (stall_cnt_o !== '0) begin n_errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt_o); end
    n_checks++;
    if (operands_a_o !== '0 || operands_b_o !== '0 || alu_op_o !== '0 || rd_addr_o !== '0 || shamt_o !== '0) begin
      n_errors++; $display("FAIL reset_regs: got a=%0h b=%0h expected 0", operands_a_o, operands_b_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_add();
    id_valid_i = 1; id_alu_op_i = 5'd0; id_rs1_addr_i = 3; id_rs1_data_i = 5;
    id_rs2_addr_i = 4; id_rs2_data_i = 7; id_rd_addr_i = 1;
    #1;
    n_checks++;
    if (id_ready_o !== 1'b1) begin n_errors++; $display("FAIL add_ready: got %b expected 1", id_ready_o); end
    step();
    id_valid_i = 0;
    n_checks++;
    if (ex_valid_o !== 1'b1 || operands_a_o !== 32'd5 || operands_b_o !== 32'd7 || alu_op_o !== 5'd0 ||
        rd_addr_o !== 5'd1 || shamt_o !== 5'd7) begin
      n_errors++;
      $display("FAIL add_capture: got v=%b a=%0h b=%0h op=%0d rd=%0d sh=%0d expected v=1 a=5 b=7 op=0 rd=1 sh=7",
               ex_valid_o, operands_a_o, operands_b_o, alu_op_o, rd_addr_o, shamt_o);
    end
    step();
    n_checks++;
    if (ex_valid_o !== 1'b0) begin n_errors++; $display("FAIL add_bubble: got %b expected 0", ex_valid_o); end
  endtask

  task automatic test_forward();
    id_valid_i = 1; id_alu_op_i = 5'd2; id_rs1_addr_i = 3; id_rs1_data_i = 32'h99;
    id_use_imm_i = 1; id_imm_i = 32'h123; id_rs2_addr_i = 3; id_rd_addr_i = 2;
    fwd_ex_valid_i = 1; fwd_ex_rd_i = 3; fwd_ex_data_i = 32'h11;
    fwd_wb_valid_i = 1; fwd_wb_rd_i = 3; fwd_wb_data_i = 32'h22;
    step();
    n_checks++;
    if (operands_a_o !== 32'h11 || operands_b_o !== 32'h123 || shamt_o !== 5'd3) begin
      n_errors++; $display("FAIL fwd_ex_priority: got a=%0h b=%0h sh=%0d expected a=11 b=123 sh=3",
                           operands_a_o, operands_b_o, shamt_o);
    end
    id_use_imm_i = 0; id_rs2_addr_i = 5; id_rs2_data_i = 32'h77; fwd_ex_rd_i = 5; fwd_ex_data_i = 32'h33;
    step();
    n_checks++;
    if (operands_a_o !== 32'h22 || operands_b_o !== 32'h33) begin
      n_errors++; $display("FAIL fwd_wb: got a=%0h b=%0h expected a=22 b=33", operands_a_o, operands_b_o);
    end
    id_rs1_addr_i = 0; id_rs1_data_i = 32'h44; fwd_ex_rd_i = 0; fwd_ex_data_i = 32'h55;
    fwd_wb_rd_i = 0; fwd_wb_data_i = 32'h66; id_rs2_addr_i = 6; id_rs2_data_i = 32'h88;
    step();
    n_checks++;
    if (operands_a_o !== 32'h0 || operands_b_o !== 32'h88) begin
      n_errors++; $display("FAIL fwd_x0: got a=%0h b=%0h expected a=0 b=88", operands_a_o, operands_b_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_load_use();
    fwd_ex_valid_i = 1; fwd_ex_is_load_i = 1; fwd_ex_rd_i = 6; fwd_ex_data_i = 32'hdead;
    id_valid_i = 1; id_alu_op_i = 5'd1; id_rs1_addr_i = 6; id_rs1_data_i = 32'h1; id_rs2_addr_i = 0;
    id_rd_addr_i = 9;
    #1;
    n_checks++;
    if (id_ready_o !== 1'b0) begin n_errors++; $display("FAIL lu_ready: got %b expected 0", id_ready_o); end
    step();
    n_checks++;
    if (ex_valid_o !== 1'b0 || stall_cnt_o !== 4'd1) begin
      n_errors++; $display("FAIL lu_bubble: got v=%b cnt=%0d expected v=0 cnt=1", ex_valid_o, stall_cnt_o);
    end
    fwd_ex_valid_i = 0; fwd_ex_is_load_i = 0; fwd_wb_valid_i = 1; fwd_wb_rd_i = 6; fwd_wb_data_i = 32'h40;
    #1;
    n_checks++;
    if (id_ready_o !== 1'b1) begin n_errors++; $display("FAIL lu_release: got %b expected 1", id_ready_o); end
    step();
    n_checks++;
    if (ex_valid_o !== 1'b1 || operands_a_o !== 32'h40 || alu_op_o !== 5'd1 || rd_addr_o !== 5'd9) begin
      n_errors++; $display("FAIL lu_capture: got v=%b a=%0h op=%0d expected v=1 a=40 op=1",
                           ex_valid_o, operands_a_o, alu_op_o);
    end
    fwd_wb_valid_i = 0;
    fwd_ex_valid_i = 1; fwd_ex_is_load_i = 1; fwd_ex_rd_i = 7;
    id_rs1_addr_i = 2; id_rs2_addr_i = 7; id_use_imm_i = 1;
    #1;
    n_checks++;
    if (id_ready_o !== 1'b1) begin n_errors++; $display("FAIL lu_imm_nohaz: got %b expected 1", id_ready_o); end
    step();
    n_checks++;
    if (stall_cnt_o !== 4'd1) begin n_errors++; $display("FAIL lu_imm_cnt: got %0d expected 1", stall_cnt_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    id_valid_i = 1; id_rs1_addr_i = 1; id_rs1_data_i = 32'haaaa; id_rs2_addr_i = 2;
    id_rs2_data_i = 32'hbbbb; id_alu_op_i = 5'd3; id_rd_addr_i = 4;
    step();
    ex_ready_i = 0;
    id_rs1_data_i = 32'hcccc; id_alu_op_i = 5'd4; id_rd_addr_i = 5;
    fwd_ex_valid_i = 1; fwd_ex_is_load_i = 1; fwd_ex_rd_i = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (id_ready_o !== 1'b0) begin n_errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, id_ready_o); end
      step();
      n_checks++;
      if (ex_valid_o !== 1'b1 || operands_a_o !== 32'haaaa || operands_b_o !== 32'hbbbb ||
          alu_op_o !== 5'd3 || rd_addr_o !== 5'd4 || stall_cnt_o !== 4'd1) begin
        n_errors++; $display("FAIL bp_hold[%0d]: got v=%b a=%0h op=%0d cnt=%0d expected v=1 a=aaaa op=3 cnt=1",
                             i, ex_valid_o, operands_a_o, alu_op_o, stall_cnt_o);
      end
    end
    fwd_ex_valid_i = 0; fwd_ex_is_load_i = 0; ex_ready_i = 1;
    #1;
    n_checks++;
    if (id_ready_o !== 1'b1) begin n_errors++; $display("FAIL bp_release: got %b expected 1", id_ready_o); end
    step();
    id_valid_i = 0;
    n_checks++;
    if (ex_valid_o !== 1'b1 || operands_a_o !== 32'hcccc || alu_op_o !== 5'd4 || rd_addr_o !== 5'd5) begin
      n_errors++; $display("FAIL bp_next: got a=%0h op=%0d expected a=cccc op=4", operands_a_o, alu_op_o);
    end
    step();
    n_checks++;
    if (ex_valid_o !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got %b expected 0", ex_valid_o); end
  endtask

  task automatic test_flush();
    id_valid_i = 1; id_rs1_addr_i = 1; id_rs1_data_i = 32'h1234; id_alu_op_i = 5'd6;
    step();
    id_rs1_data_i = 32'h5678; id_alu_op_i = 5'd7; flush_i = 1;
    #1;
    n_checks++;
    if (ex_valid_o !== 1'b1 || id_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL flush_pre: got v=%b rdy=%b expected v=1 rdy=0", ex_valid_o, id_ready_o);
    end
    step();
    flush_i = 0; id_valid_i = 0;
    n_checks++;
    if (ex_valid_o !== 1'b0) begin n_errors++; $display("FAIL flush_kill: got %b expected 0", ex_valid_o); end
    step();
    n_checks++;
    if (ex_valid_o !== 1'b0) begin n_errors++; $display("FAIL flush_nocap: got %b expected 0", ex_valid_o); end
  endtask

  task automatic test_saturate();
    idle_inputs();
    fwd_ex_valid_i = 1; fwd_ex_is_load_i = 1; fwd_ex_rd_i = 6;
    id_valid_i = 1; id_rs1_addr_i = 6;
    repeat (20) step();
    n_checks++;
    if (stall_cnt_o !== 4'hf) begin n_errors++; $display("FAIL stall_sat: got %0d expected 15", stall_cnt_o); end
    idle_inputs();
    step();
  endtask

  function automatic logic [DW-1:0] ref_src(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    if (a == 0) return '0;
    if (fwd_ex_valid_i && fwd_ex_rd_i == a) return fwd_ex_data_i;
    if (fwd_wb_valid_i && fwd_wb_rd_i == a) return fwd_wb_data_i;
    return rf;
  endfunction

  task automatic test_random();
    bit m_valid;
    logic [DW-1:0] m_a, m_b;
    logic [4:0] m_op;
    logic [AW-1:0] m_rd;
    int m_cnt;
    bit hz, free, rdy;
    logic [DW-1:0] ra, rb;
    int errs_before;
    idle_inputs();
    rst_i = 1;
    step();
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_cnt = 0;
    errs_before = n_errors;
    for (int c = 0; c < 400; c++) begin
      rst_i = ($urandom_range(0, 40) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      ex_ready_i = ($urandom_range(0, 3) != 0);
      id_valid_i = ($urandom_range(0, 3) != 0);
      id_alu_op_i = 5'($urandom);
      id_rs1_addr_i = AW'($urandom_range(0, 7));
      id_rs2_addr_i = AW'($urandom_range(0, 7));
      id_rd_addr_i = AW'($urandom_range(0, 31));
      id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
      id_use_imm_i = $urandom_range(0, 1);
      fwd_ex_valid_i = $urandom_range(0, 1); fwd_ex_rd_i = AW'($urandom_range(0, 7));
      fwd_ex_data_i = $urandom; fwd_ex_is_load_i = ($urandom_range(0, 2) == 0);
      fwd_wb_valid_i = $urandom_range(0, 1); fwd_wb_rd_i = AW'($urandom_range(0, 7));
      fwd_wb_data_i = $urandom;
      #1;
      hz = id_valid_i && fwd_ex_valid_i && fwd_ex_is_load_i && fwd_ex_rd_i != 0 &&
           (fwd_ex_rd_i == id_rs1_addr_i || (!id_use_imm_i && fwd_ex_rd_i == id_rs2_addr_i));
      free = !m_valid || ex_ready_i;
      rdy = free && !hz && !rst_i && !flush_i;
      ra = ref_src(id_rs1_addr_i, id_rs1_data_i);
      rb = id_use_imm_i ? id_imm_i : ref_src(id_rs2_addr_i, id_rs2_data_i);
      n_checks++;
      if (id_ready_o !== rdy) begin
        n_errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, id_ready_o, rdy);
      end
      if (rst_i) begin
        m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_cnt = 0;
      end else begin
        if (free && hz && !flush_i && m_cnt < (1 << PW) - 1) m_cnt++;
        if (flush_i) m_valid = 0;
        else if (id_valid_i && rdy) begin
          m_valid = 1; m_a = ra; m_b = rb; m_op = id_alu_op_i; m_rd = id_rd_addr_i;
        end else if (free) m_valid = 0;
      end
      step();
      n_checks++;
      if (ex_valid_o !== m_valid || stall_cnt_o !== PW'(m_cnt)) begin
        n_errors++; $display("FAIL rnd_state[%0d]: got v=%b cnt=%0d expected v=%b cnt=%0d",
                             c, ex_valid_o, stall_cnt_o, m_valid, m_cnt);
      end
      if (m_valid) begin
        n_checks++;
        if (operands_a_o !== m_a || operands_b_o !== m_b || alu_op_o !== m_op || rd_addr_o !== m_rd ||
            shamt_o !== m_b[SW-1:0]) begin
          n_errors++; $display("FAIL rnd_data[%0d]: got a=%0h b=%0h op=%0d rd=%0d expected a=%0h b=%0h op=%0d rd=%0d",
                               c, operands_a_o, operands_b_o, alu_op_o, rd_addr_o, m_a, m_b, m_op, m_rd);
        end
      end
      if (n_errors - errs_before > 10) break;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
